// File: rtl/plru_victim_alloc_if.sv
// +--------------------------------------------------------------------------+
// | plru_victim_alloc_if : hit and allocation handshake bundle               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface plru_victim_alloc_if #(
  parameter int ENTRIES = 16
);
  logic               hit_valid_i;
  logic [ENTRIES-1:0] hit_idx_i;
  logic               hit_ready_o;
  logic               alloc_req_i;
  logic               alloc_gnt_o;
  logic [ENTRIES-1:0] alloc_idx_o;
  logic               refill_done_i;

  modport slave (
    input  hit_valid_i, hit_idx_i, alloc_req_i, refill_done_i,
    output hit_ready_o, alloc_gnt_o, alloc_idx_o
  );

  modport master (
    output hit_valid_i, hit_idx_i, alloc_req_i, refill_done_i,
    input  hit_ready_o, alloc_gnt_o, alloc_idx_o
  );
endinterface

`default_nettype wire

// File: rtl/plru_victim_alloc.sv
// +--------------------------------------------------------------------------+
// | plru_victim_alloc : victim pick, valid tracking and used vector for PLRU |
// | Optional lock support: PLRU_ALLOC_LOCK_EN          Rev 1.0               |
// +--------------------------------------------------------------------------+
`default_nettype none

module plru_victim_alloc #(
  parameter int ENTRIES = 16
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  plru_victim_alloc_if.slave      bus,
  input  wire logic               flush_i,
  input  wire logic [ENTRIES-1:0] inv_i,
  input  wire logic [ENTRIES-1:0] plru_i,
  output logic      [ENTRIES-1:0] used_o,
  output logic                    plru_clr_o,
  output logic      [ENTRIES-1:0] valid_o
`ifdef PLRU_ALLOC_LOCK_EN
  ,
  input  wire logic [ENTRIES-1:0] lock_i,
  output logic                    alloc_err_o
`endif
);

  localparam logic [ENTRIES-1:0] C_ENTRY0 = ENTRIES'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PICK = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e             state_q;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] victim_q, victim_d;
  logic               gnt_q;
  logic               pick_err;
  logic               commit;
  logic [ENTRIES-1:0] inv_eff;

  function automatic logic [ENTRIES-1:0] f_lowbit(input logic [ENTRIES-1:0] v);
    return v & (~v + C_ENTRY0);
  endfunction

  // Invalid entries are preferred; the tree's LRU only matters when the set is full.
  always_comb begin
    pick_err = 1'b0;
`ifdef PLRU_ALLOC_LOCK_EN
    if (|(~valid_q & ~lock_i))
      victim_d = f_lowbit(~valid_q & ~lock_i);
    else if (|(plru_i & ~lock_i))
      victim_d = plru_i & ~lock_i;
    else
      victim_d = f_lowbit(~lock_i);
    pick_err = ~|(~lock_i);
`else
    if (|(~valid_q))
      victim_d = f_lowbit(~valid_q);
    else if (|plru_i)
      victim_d = plru_i;
    else
      victim_d = C_ENTRY0;
`endif
  end

  always_comb begin
    commit  = (state_q == S_WAIT) && bus.refill_done_i;
    inv_eff = inv_i & ~((state_q == S_WAIT) ? victim_q : '0);
    valid_d = flush_i ? '0 : (valid_q & ~inv_eff);
    if (commit)
      valid_d = valid_d | victim_q;
  end

  // A commit steals the used port; the hit source retries next cycle.
  always_comb begin
    if (commit) begin
      used_o          = flush_i ? '0 : victim_q;
      bus.hit_ready_o = 1'b0;
    end else begin
      used_o          = bus.hit_valid_i ? bus.hit_idx_i : '0;
      bus.hit_ready_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      victim_q <= '0;
      gnt_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      gnt_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.alloc_req_i)
            state_q <= S_PICK;
        end
        S_PICK: begin
          if (pick_err) begin
            state_q <= S_IDLE;
          end else begin
            victim_q <= victim_d;
            gnt_q    <= 1'b1;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.refill_done_i) begin
            victim_q <= '0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.alloc_gnt_o = gnt_q;
  assign bus.alloc_idx_o = victim_q;
  assign plru_clr_o      = flush_i;
  assign valid_o         = valid_q;
`ifdef PLRU_ALLOC_LOCK_EN
  assign alloc_err_o     = (state_q == S_PICK) && pick_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_plru_victim_alloc.sv
// +--------------------------------------------------------------------------+
// | tb_plru_victim_alloc : scoreboard bench for plru_victim_alloc, 4 entries |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_plru_victim_alloc;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [N-1:0] inv = '0;
  logic [N-1:0] plru = '0;
  logic [N-1:0] used;
  logic         clr;
  logic [N-1:0] valid;
  logic [N-1:0] lock = '0;
  logic         err;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] model_valid = '0;
  logic [N-1:0] exp_q[$];

  plru_victim_alloc_if #(.ENTRIES(N)) bus ();

  plru_victim_alloc #(.ENTRIES(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .flush_i    (flush),
    .inv_i      (inv),
    .plru_i     (plru),
    .used_o     (used),
    .plru_clr_o (clr),
    .valid_o    (valid)
`ifdef PLRU_ALLOC_LOCK_EN
    ,
    .lock_i     (lock),
    .alloc_err_o(err)
`endif
  );
`ifndef PLRU_ALLOC_LOCK_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference victim choice: first free unlocked entry, else unlocked LRU, else first unlocked.
  function automatic logic [N-1:0] ref_victim(input logic [N-1:0] v, input logic [N-1:0] p,
                                              input logic [N-1:0] lk);
    for (int i = 0; i < N; i++)
      if (!v[i] && !lk[i]) return N'(1) << i;
    if ((p & ~lk) != '0) return p & ~lk;
    for (int i = 0; i < N; i++)
      if (!lk[i]) return N'(1) << i;
    return '0;
  endfunction

  task automatic do_alloc(input logic [N-1:0] p, input bit hit, input bit flsh_w,
                          input bit inv_w, input bit flsh_c);
    logic [N-1:0] v;
    logic [N-1:0] pre;
    int cyc;
    exp_q.push_back(ref_victim(model_valid, p, lock));
    pre = model_valid;
    plru = p;
    bus.alloc_req_i = 1'b1;
    cyc = 0;
    while (!bus.alloc_gnt_o && cyc < 8) begin
      step();
      cyc++;
    end
    bus.alloc_req_i = 1'b0;
    v = exp_q.pop_front();
    chk("gnt_latency", cyc, 2);
    if (bus.alloc_gnt_o) begin
      chk("alloc_idx", bus.alloc_idx_o, v);
      chk("valid_in_wait", valid, pre);
      step();
      chk("gnt_one_cycle", bus.alloc_gnt_o, 0);
      chk("idx_held", bus.alloc_idx_o, v);
      if (inv_w) begin
        inv = v;
        step();
        inv = '0;
        chk("inv_reserved_masked", valid, model_valid);
      end
      if (flsh_w) begin
        flush = 1'b1;
        #1 chk("clr_on_flush", clr, 1);
        step();
        flush = 1'b0;
        model_valid = '0;
        chk("valid_after_flush", valid, model_valid);
        chk("idx_after_flush", bus.alloc_idx_o, v);
      end
      bus.refill_done_i = 1'b1;
      flush = flsh_c;
      if (hit) begin
        bus.hit_valid_i = 1'b1;
        bus.hit_idx_i   = 4'b0001;
      end
      #1;
      chk("commit_used", used, flsh_c ? 4'b0000 : v);
      chk("commit_hit_ready", bus.hit_ready_o, 0);
      step();
      bus.refill_done_i = 1'b0;
      flush = 1'b0;
      model_valid = (flsh_c ? '0 : model_valid) | v;
      chk("valid_after_commit", valid, model_valid);
      chk("idx_after_commit", bus.alloc_idx_o, 0);
      if (hit) begin
        chk("hit_retry_used", used, 4'b0001);
        chk("hit_retry_ready", bus.hit_ready_o, 1);
        bus.hit_valid_i = 1'b0;
        bus.hit_idx_i   = '0;
      end
    end
  endtask

  initial begin
    bus.hit_valid_i   = 1'b0;
    bus.hit_idx_i     = '0;
    bus.alloc_req_i   = 1'b0;
    bus.refill_done_i = 1'b0;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_gnt", bus.alloc_gnt_o, 0);
    chk("rst_idx", bus.alloc_idx_o, 0);
    chk("rst_used", used, 0);
    chk("rst_hit_ready", bus.hit_ready_o, 1);
    chk("rst_clr", clr, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();

    // Fill from empty, then full-set allocations
    for (int i = 0; i < N; i++) do_alloc(4'b0000, 0, 0, 0, 0);
    chk("valid_full", valid, 4'b1111);
    do_alloc(4'b0100, 0, 0, 0, 0);
    do_alloc(4'b1000, 1, 0, 0, 0);

    inv = 4'b0010;
    step();
    inv = '0;
    model_valid = 4'b1101;
    chk("valid_after_inv", valid, model_valid);
    do_alloc(4'b0001, 0, 0, 0, 0);
    do_alloc(4'b0100, 0, 0, 1, 0);

    inv = 4'b0100;
    step();
    inv = '0;
    model_valid = 4'b1011;
    do_alloc(4'b0001, 0, 1, 0, 0);
    do_alloc(4'b0000, 0, 0, 0, 1);
    chk("flush_commit_valid", valid, 4'b0001);
    for (int i = 0; i < N - 1; i++) do_alloc(4'b0000, 0, 0, 0, 0);
    do_alloc(4'b0000, 0, 0, 0, 0);

    bus.refill_done_i = 1'b1;
    #1 chk("idle_refill_used", used, 0);
    step();
    bus.refill_done_i = 1'b0;
    chk("idle_refill_valid", valid, model_valid);

    // Asynchronous reset while a reservation is outstanding
    exp_q.push_back(ref_victim(model_valid, 4'b0010, lock));
    plru = 4'b0010;
    bus.alloc_req_i = 1'b1;
    step();
    step();
    bus.alloc_req_i = 1'b0;
    chk("pre_rst_gnt", bus.alloc_gnt_o, 1);
    chk("pre_rst_idx", bus.alloc_idx_o, exp_q.pop_front());
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", valid, 0);
    chk("async_rst_idx", bus.alloc_idx_o, 0);
    chk("async_rst_gnt", bus.alloc_gnt_o, 0);
    step();
    rst = 1'b0;
    model_valid = '0;
    step();
    do_alloc(4'b1000, 0, 0, 0, 0);

`ifdef PLRU_ALLOC_LOCK_EN
    for (int i = 0; i < N - 1; i++) do_alloc(4'b0000, 0, 0, 0, 0);
    lock = 4'b1111;
    bus.alloc_req_i = 1'b1;
    step();
    chk("lock_err_pulse", err, 1);
    bus.alloc_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock_no_gnt", bus.alloc_gnt_o, 0);
    end
    chk("lock_err_cleared", err, 0);
    chk("lock_valid_kept", valid, 4'b1111);
    lock = 4'b0100;
    do_alloc(4'b0100, 0, 0, 0, 0);
    lock = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
